// File: rtl/window_3x3_gen_pkg.sv
// win_pkg: shared types and constants for the 3x3 window generator
package win_pkg;
  localparam int DSIZE = 4;
  localparam int WIN_TAPS = 9;
  typedef logic [DSIZE-1:0] pixel_t;
  typedef logic [WIN_TAPS*DSIZE-1:0] window_t;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// line_buffer: DEPTH-deep shift-on-enable delay line
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      mem[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end
  assign o_dout = mem[DEPTH-1];
endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster pixel stream to zero-padded 3x3 neighbourhoods
module window_3x3_gen #(
  parameter int DSIZE = 4,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_sof,
  input  logic [DSIZE-1:0]   i_pixel,
  output logic               o_ready,
  output logic               o_valid,
  output logic [9*DSIZE-1:0] o_window
);
  import win_pkg::*;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 1);
  state_t state;
  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;
  logic [FW-1:0] fcnt;
  logic [DSIZE-1:0] win [9];
  logic [DSIZE-1:0] nxt [9];
  logic [DSIZE-1:0] tap [3];
  logic [DSIZE-1:0] din, lb1, lb2;
  logic [9*DSIZE-1:0] masked;
  logic acc, start, step, primed, emit, last_px;
  assign o_ready = state != FLUSH;
  always_comb begin
    acc = i_valid && o_ready;
    start = acc && i_sof;
    step = start || (acc && state == STREAM) || state == FLUSH;
    din = state == FLUSH ? '0 : i_pixel;
    primed = y > YW'(1) || (y == YW'(1) && x != '0);
    emit = state == FLUSH || (acc && !i_sof && state == STREAM && primed);
    last_px = x == XW'(IMG_W - 1) && y == YW'(IMG_H - 1);
  end
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DSIZE)) u_lb1 (.i_clk, .i_en(step), .i_din(din), .o_dout(lb1));
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DSIZE)) u_lb2 (.i_clk, .i_en(step), .i_din(lb1), .o_dout(lb2));
  assign tap[0] = lb2;
  assign tap[1] = lb1;
  assign tap[2] = din;
  // Masking keys off the centre position only, so stale line-buffer data never crosses a border
  for (genvar i = 0; i < 9; i++) begin : g_win
    if (i % 3 == 2) begin : g_new
      assign nxt[i] = tap[i/3];
    end else begin : g_old
      assign nxt[i] = win[i+1];
    end
    assign masked[(8-i)*DSIZE +: DSIZE] =
      ((i / 3 == 0 && cy == '0) || (i / 3 == 2 && cy == YW'(IMG_H - 1)) ||
       (i % 3 == 0 && cx == '0) || (i % 3 == 2 && cx == XW'(IMG_W - 1))) ? '0 : nxt[i];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      cx <= '0;
      cy <= '0;
      fcnt <= '0;
      win <= '{default: '0};
      o_valid <= 1'b0;
      o_window <= '0;
    end else begin
      o_valid <= emit;
      if (emit) o_window <= masked;
      if (step) win <= nxt;
      if (emit) begin
        cx <= cx == XW'(IMG_W - 1) ? '0 : cx + XW'(1);
        cy <= cx == XW'(IMG_W - 1) ? cy + YW'(1) : cy;
      end
      if (start) begin
        state <= STREAM;
        x <= XW'(1);
        y <= '0;
        cx <= '0;
        cy <= '0;
      end else if (state == STREAM && acc) begin
        if (last_px) begin
          state <= FLUSH;
          fcnt <= '0;
        end else begin
          x <= x == XW'(IMG_W - 1) ? '0 : x + XW'(1);
          y <= x == XW'(IMG_W - 1) ? y + YW'(1) : y;
        end
      end else if (state == FLUSH) begin
        fcnt <= fcnt + FW'(1);
        if (fcnt == FW'(IMG_W)) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: scoreboard bench for window_3x3_gen on a 4x3 image
module tb_window_3x3_gen;
  localparam int W = 4;
  localparam int H = 3;
  localparam int D = 4;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_valid = 1'b0;
  logic i_sof = 1'b0;
  logic [D-1:0] i_pixel = '0;
  logic o_ready, o_valid;
  logic [9*D-1:0] o_window;
  logic [35:0] tbl [12] = '{
    36'h000_012_056, 36'h000_123_567, 36'h000_234_678, 36'h000_340_780,
    36'h012_056_09A, 36'h123_567_9AB, 36'h234_678_ABC, 36'h340_780_BC0,
    36'h056_09A_000, 36'h567_9AB_000, 36'h678_ABC_000, 36'h780_BC0_000};
  logic [35:0] q [$];
  logic [35:0] e;
  int checks = 0;
  int errors = 0;
  always #5 i_clk = ~i_clk;
  window_3x3_gen #(.DSIZE(D), .IMG_W(W), .IMG_H(H)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sof(i_sof), .i_pixel(i_pixel),
    .o_ready(o_ready), .o_valid(o_valid), .o_window(o_window));
  // Expected windows are queued right after their accept edge, so they must appear by the next negedge
  always @(negedge i_clk) begin
    if (o_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL window_unexpected: got o_valid=1 window=%h, required no window", o_window);
      end else begin
        e = q.pop_front();
        if (o_window !== e) begin
          errors++;
          $display("FAIL window: got %h required %h", o_window, e);
        end
      end
    end else if (q.size() != 0) begin
      checks++;
      errors++;
      e = q.pop_front();
      $display("FAIL window_missing: got o_valid=0, required window %h", e);
    end
  end
  task automatic check(input string n, input logic [35:0] got, input logic [35:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, got, req);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic send(input int k, input bit sof, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) begin
      i_valid = 1'b0;
      tick();
    end
    i_valid = 1'b1;
    i_sof = sof;
    i_pixel = D'(k + 1);
    tick();
    i_valid = 1'b0;
    i_sof = 1'b0;
    if (k >= W + 1) q.push_back(tbl[k-W-1]);
  endtask
  task automatic flush(input bit hold);
    i_valid = hold;
    i_pixel = 4'hF;
    check("ready_flush", {35'd0, o_ready}, 36'd0);
    for (int j = 0; j <= W; j++) begin
      tick();
      q.push_back(tbl[W*H-W-1+j]);
      check(j < W ? "ready_flush" : "ready_after_flush", {35'd0, o_ready}, j < W ? 36'd0 : 36'd1);
    end
    if (hold) repeat (3) tick();
    i_valid = 1'b0;
  endtask
  task automatic frame(input bit gaps, input bit hold);
    for (int k = 0; k < W*H; k++) send(k, k == 0, gaps);
    flush(hold);
  endtask
  initial begin
    repeat (3) tick();
    check("reset_valid", {35'd0, o_valid}, 36'd0);
    check("reset_window", o_window, 36'd0);
    check("reset_ready", {35'd0, o_ready}, 36'd1);
    i_rst = 1'b0;
    i_valid = 1'b1;
    i_pixel = 4'h9;
    repeat (3) tick();
    i_valid = 1'b0;
    tick();
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    for (int k = 0; k < 7; k++) send(k, k == 0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b0);
    for (int k = 0; k < W*H; k++) send(k, k == 0, 1'b0);
    check("ready_flush", {35'd0, o_ready}, 36'd0);
    tick();
    q.push_back(tbl[W*H-W-1]);
    i_rst = 1'b1;
    tick();
    check("rst_flush_valid", {35'd0, o_valid}, 36'd0);
    check("rst_flush_ready", {35'd0, o_ready}, 36'd1);
    i_rst = 1'b0;
    repeat (6) begin
      tick();
      check("rst_flush_quiet", {35'd0, o_valid}, 36'd0);
    end
    frame(1'b1, 1'b0);
    repeat (3) tick();
    check("queue_drained", 36'(q.size()), 36'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
